// File: rtl/bomb_controller_pkg.sv
// Shared game definitions for the bomb / explosion logic.
//   - state_e    : bomb FSM encoding (IDLE=0, ARMED=1, BLAST=2)
//   - TILE_PX    : grid tile size in pixels
//   - ARM_REACH_PX : blast arm length beyond the centre tile
//   - SCREEN_W/H : visible screen limits
//   - snap_to_tile : rounds a sprite top-left to the nearest tile origin
package bomb_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BLAST = 2'd2
  } state_e;

  localparam int TILE_PX      = 16;
  localparam int ARM_REACH_PX = 48;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;

  // Adding half a tile before masking picks the tile under the sprite's
  // centre rather than under its top-left corner. The sum is 11 bits wide
  // and deliberately truncated back to 10.
  function automatic logic [9:0] snap_to_tile(input logic [9:0] pos, input int tile);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(tile / 2);
    return sum[9:0] & ~10'(tile - 1);
  endfunction

endpackage

// File: rtl/bomb_controller_blast_region_hit.sv
// Pixel comparator for the bomb tile and the plus-shaped blast.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   v_x, v_y       : current VGA pixel
//   e_x, e_y       : bomb tile top-left
//   in_tile        : registered, pixel lies inside the bomb tile
//   in_plus        : registered, pixel lies inside the blast plus shape
module blast_region_hit
  import bomb_controller_pkg::*;
#(
  parameter int TILE      = TILE_PX,
  parameter int ARM_REACH = ARM_REACH_PX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  input  logic [9:0] e_x,
  input  logic [9:0] e_y,
  output logic       in_tile,
  output logic       in_plus
);

  // One guard bit above the 11-bit signed range keeps e+ARM_REACH+TILE-1
  // from wrapping negative for tiles near the right/bottom edge.
  localparam logic signed [11:0] ARM_S  = 12'(ARM_REACH);
  localparam logic signed [11:0] TILE_S = 12'(TILE - 1);

  logic signed [11:0] vx_s, vy_s, ex_s, ey_s;
  logic signed [11:0] lo_x, hi_x, lo_y, hi_y, lo_x_raw, lo_y_raw;
  logic               col_hit, row_hit, hband, vband;
  logic               in_tile_d, in_plus_d;
  logic               in_tile_q, in_plus_q;

  always_comb begin
    vx_s     = $signed({2'b00, v_x});
    vy_s     = $signed({2'b00, v_y});
    ex_s     = $signed({2'b00, e_x});
    ey_s     = $signed({2'b00, e_y});
    lo_x_raw = ex_s - ARM_S;
    lo_y_raw = ey_s - ARM_S;
    // Arms clip at the screen origin instead of wrapping around.
    lo_x     = (lo_x_raw < 0) ? 12'sd0 : lo_x_raw;
    lo_y     = (lo_y_raw < 0) ? 12'sd0 : lo_y_raw;
    hi_x     = ex_s + ARM_S + TILE_S;
    hi_y     = ey_s + ARM_S + TILE_S;
    col_hit  = (vx_s >= ex_s) && (vx_s <= ex_s + TILE_S);
    row_hit  = (vy_s >= ey_s) && (vy_s <= ey_s + TILE_S);
    hband    = row_hit && (vx_s >= lo_x) && (vx_s <= hi_x);
    vband    = col_hit && (vy_s >= lo_y) && (vy_s <= hi_y);
    in_tile_d = col_hit && row_hit;
    in_plus_d = hband || vband;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_tile_q <= 1'b0;
      in_plus_q <= 1'b0;
    end else begin
      in_tile_q <= in_tile_d;
      in_plus_q <= in_plus_d;
    end
  end

  assign in_tile = in_tile_q;
  assign in_plus = in_plus_q;

endmodule

// File: rtl/bomb_controller.sv
// Bomb placement, fuse and blast sequencing; producer of the explosion
// interface for the box/wall logic.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   frame_tick        : one-cycle pulse per video frame (time base)
//   place_bomb        : one-cycle placement request
//   b_x, b_y          : Bomberman top-left position
//   v_x, v_y          : current VGA pixel
//   e_x, e_y          : bomb/explosion tile top-left, held between placements
//   explosion_SCEN    : one-cycle detonation pulse
//   bomb_on           : registered pixel flag, bomb tile while armed
//   explosion_on      : registered pixel flag, blast plus while blasting
//   busy              : bomb armed or blast being shown
module bomb_controller
  import bomb_controller_pkg::*;
#(
  parameter int FUSE_TICKS  = 120,
  parameter int BLAST_TICKS = 30,
  parameter int TILE        = TILE_PX,
  parameter int ARM_REACH   = ARM_REACH_PX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       place_bomb,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       explosion_SCEN,
  output logic       bomb_on,
  output logic       explosion_on,
  output logic       busy
);

  localparam int FUSE_W  = $clog2(FUSE_TICKS + 1);
  localparam int BLAST_W = $clog2(BLAST_TICKS + 1);

  state_e             state_q, state_d;
  logic [FUSE_W-1:0]  fuse_q, fuse_d;
  logic [BLAST_W-1:0] blast_q, blast_d;
  logic [9:0]         e_x_q, e_x_d, e_y_q, e_y_d;
  logic               scen_q, scen_d;
  logic               in_tile, in_plus;

  always_comb begin
    state_d = state_q;
    fuse_d  = fuse_q;
    blast_d = blast_q;
    e_x_d   = e_x_q;
    e_y_d   = e_y_q;
    scen_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A coincident frame_tick is ignored here, so the fresh fuse
        // always gets its full FUSE_TICKS.
        if (place_bomb) begin
          e_x_d   = snap_to_tile(b_x, TILE);
          e_y_d   = snap_to_tile(b_y, TILE);
          fuse_d  = FUSE_W'(FUSE_TICKS);
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (frame_tick) begin
          if (fuse_q == FUSE_W'(1)) begin
            fuse_d  = '0;
            blast_d = BLAST_W'(BLAST_TICKS);
            scen_d  = 1'b1;
            state_d = ST_BLAST;
          end else begin
            fuse_d = fuse_q - FUSE_W'(1);
          end
        end
      end
      ST_BLAST: begin
        if (frame_tick) begin
          if (blast_q == BLAST_W'(1)) begin
            blast_d = '0;
            state_d = ST_IDLE;
          end else begin
            blast_d = blast_q - BLAST_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      fuse_q  <= '0;
      blast_q <= '0;
      e_x_q   <= '0;
      e_y_q   <= '0;
      scen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fuse_q  <= fuse_d;
      blast_q <= blast_d;
      e_x_q   <= e_x_d;
      e_y_q   <= e_y_d;
      scen_q  <= scen_d;
    end
  end

  blast_region_hit #(
    .TILE      (TILE),
    .ARM_REACH (ARM_REACH)
  ) u_hit (
    .clk     (clk),
    .reset   (reset),
    .v_x     (v_x),
    .v_y     (v_y),
    .e_x     (e_x_q),
    .e_y     (e_y_q),
    .in_tile (in_tile),
    .in_plus (in_plus)
  );

  // Gating uses the registered state, so a reset clears the flags at once.
  assign bomb_on        = in_tile && (state_q == ST_ARMED);
  assign explosion_on   = in_plus && (state_q == ST_BLAST);
  assign busy           = (state_q != ST_IDLE);
  assign e_x            = e_x_q;
  assign e_y            = e_y_q;
  assign explosion_SCEN = scen_q;

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Producer side of the explosion interface consumed by the box/wall logic. It accepts a single-cycle bomb-placement request and snaps the bomb to the 16-px tile grid at Bomberman's position. It then runs a fuse countdown and a blast-display countdown on the frame tick. It drives the explosion location with a one-cycle `explosion_SCEN` pulse, and provides registered per-pixel `bomb_on` / `explosion_on` flags for the top-level pixel mux.

## Interface
Parameters:
- `FUSE_TICKS`, 120: frame ticks from placement to detonation, ≥1.
- `BLAST_TICKS`, 30: frame ticks the explosion stays drawn, ≥1.
- `TILE`, 16: tile size in px, power of two.
- `ARM_REACH`, 48: arm length beyond the centre tile, in px.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: single-cycle pulse, once per video frame.
- `place_bomb`, in, 1: single-cycle enable from the debounced button.
- `b_x`, `b_y`, in, 10: Bomberman top-left position.
- `v_x`, `v_y`, in, 10: current VGA pixel.
- `e_x`, `e_y`, out, 10: bomb/explosion tile top-left; held between placements.
- `explosion_SCEN`, out, 1: detonation pulse, exactly one cycle wide.
- `bomb_on`, out, 1: current pixel lies in the bomb tile while armed.
- `explosion_on`, out, 1: current pixel lies in the plus-shaped blast while blasting.
- `busy`, out, 1: high in ARMED or BLAST.

## Operation
- FSM states are IDLE, ARMED and BLAST. `reset` low forces IDLE immediately.
- **IDLE -> ARMED:** on a `clk` edge with `place_bomb`=1 and state IDLE.
  - Same edge: `e_x` <= ((b_x+TILE/2) & ~(TILE-1)), same rule for `e_y`.
  - The add is 11-bit; the result is truncated to 10 bits.
  - Same edge: `fuse_cnt` <= FUSE_TICKS.
- **ARMED:** each `frame_tick` decrements `fuse_cnt`. On a `frame_tick` with `fuse_cnt`==1:
  - state <= BLAST,
  - `explosion_SCEN` <= 1,
  - `blast_cnt` <= BLAST_TICKS.
- **BLAST:** each `frame_tick` decrements `blast_cnt`. On a `frame_tick` with `blast_cnt`==1, state <= IDLE.
- `place_bomb` is ignored in ARMED and BLAST, including on the edge where BLAST exits to IDLE. There is no queueing.
- `e_x` / `e_y` change only on an accepted placement. They are stable before, during and after the `explosion_SCEN` cycle.
- **Bomb tile:** `v_x` in [e_x, e_x+TILE-1] and `v_y` in [e_y, e_y+TILE-1].
- **Blast region:** the union of two bands.
  - Horizontal band: `v_x` in [e_x-ARM_REACH, e_x+ARM_REACH+TILE-1] and `v_y` in the centre-tile rows.
  - Vertical band: `v_y` in [e_y-ARM_REACH, e_y+ARM_REACH+TILE-1] and `v_x` in the centre-tile columns.
  - Compare in 11-bit signed. A negative lower bound is treated as 0; no wrap-around.

## Timing
- Reset values: state IDLE, `e_x`=0, `e_y`=0, `explosion_SCEN`=0, `bomb_on`=0, `explosion_on`=0, `busy`=0. Counters are 0.
- `busy` is registered and is high the cycle after an accepted `place_bomb`.
- Detonation latency: `explosion_SCEN` is high exactly one cycle, starting FUSE_TICKS `frame_tick`s after placement. It is registered and asserted the cycle after the terminal tick edge.
- `frame_tick` coincident with `place_bomb` in IDLE does not decrement the freshly loaded fuse.
- `bomb_on` / `explosion_on` are registered with 1-cycle latency from `v_x` / `v_y`, aligned with the box block's registered pixel flags.
  - `bomb_on` is gated by state ARMED.
  - `explosion_on` is gated by state BLAST.
  - Both are evaluated on the registered state.
- Reset asserted mid-fuse or mid-blast: immediate return to IDLE. No `explosion_SCEN` is emitted, and none is emitted after release.

## Structure
- Shared game package holds:
  - state encoding (IDLE=0, ARMED=1, BLAST=2),
  - TILE and ARM_REACH,
  - screen limits (640x480).
- One sub-module, `blast_region_hit`: combinational plus-shape/tile comparator. Inputs are `v_x`, `v_y`, `e_x`, `e_y`; outputs are `in_tile` and `in_plus`. The block registers its outputs.
- Counters are sized by $clog2 of (FUSE_TICKS+1) and (BLAST_TICKS+1).

## Test plan
Unless noted, FUSE_TICKS=3 and BLAST_TICKS=2.
- **Placement snap:** b=(165,72), `place_bomb` -> `e_x`=160, `e_y`=80, `busy`=1 the next cycle.
- **Fuse count:** after placement, apply 3 `frame_tick`s -> `explosion_SCEN`=1 for exactly one cycle following the 3rd tick; after 2 more ticks `busy`=0.
- **Ignored request:** `place_bomb` during ARMED with b=(300,300) -> `e_x` / `e_y` stay 160/80. Exactly one `explosion_SCEN` is produced.
- **Pixel flags:** `e`=(160,80) in BLAST.
  - `v`=(112,85) -> `explosion_on`=1 one cycle later.
  - `v`=(111,85) -> 0.
  - `v`=(165,143) -> 1.
  - `v`=(176,96) -> 0.
  - In ARMED, `v`=(175,95) -> `bomb_on`=1 and `explosion_on`=0.
- **Edge clamp:** b=(0,0) -> `e`=(0,0). In BLAST, `v`=(0,60) -> `explosion_on`=1, with no false hits at `v_x`≈1000.
- **Reset mid-fuse:** `reset` low after 2 ticks -> all outputs 0 immediately. 10 further ticks after release -> no `explosion_SCEN`.
